// File: rtl/touch_pkg.sv
// Shared definitions for the touch-ADC serial receive path: state encoding,
// conversion width and the frame positions of the first X and Y data bits.
package touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX_X = 2'd1,
    ST_RX_Y = 2'd2
  } rx_state_e;

  localparam int RES_DEF           = 12;
  localparam int X_FIRST_COUNT_DEF = 19;
  localparam int Y_FIRST_COUNT_DEF = 51;

  localparam logic [6:0] FRAME_START_COUNT = 7'd0;

  // COUNT position of data bit k of a word whose MSB lands at first_count
  function automatic logic [7:0] bit_position(input int first_count, input int k);
    return 8'(first_count + 2 * k);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture; both stages reset to the idle level of the input
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_dout_rx.sv
// Serial receiver for the touch ADC: captures an X then a Y conversion at
// fixed frame positions and publishes them as a pair.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a frame start (COUNT=0 tick) with the pen down
// RX_X    | shifting in X bits at X_FIRST_COUNT, +2, ...
// RX_Y    | shifting in Y bits at Y_FIRST_COUNT, +2, ...; publishes on last
module adc_dout_rx import touch_pkg::*; #(
  parameter int X_FIRST_COUNT = X_FIRST_COUNT_DEF,
  parameter int Y_FIRST_COUNT = Y_FIRST_COUNT_DEF,
  parameter int RES           = RES_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ENABLE,
  input  logic [6:0]     COUNT,
  input  logic           ADC_DOUT,
  input  logic           PENIRQ_n,
  output logic [RES-1:0] X_COORD,
  output logic [RES-1:0] Y_COORD,
  output logic           DATA_VALID,
  output logic           PEN_DOWN,
  output logic           FRAME_ERR
);

  localparam int BW = $clog2(RES + 1);

  logic           penirq_s;
  rx_state_e      state;
  logic [BW-1:0]  bit_cnt;
  logic [RES-1:0] shift_q;
  logic [RES-1:0] x_hold;

  logic           frame_start;
  logic           x_hit;
  logic           y_hit;
  logic           last_bit;
  logic [RES-1:0] shift_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_pen_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (PENIRQ_n),
    .q   (penirq_s)
  );

  assign PEN_DOWN = ~penirq_s;

  // decode the current tick: frame start, and whether COUNT is the slot of the next expected bit
  always_comb begin
    frame_start = ENABLE && (COUNT == FRAME_START_COUNT);
    last_bit    = (int'(bit_cnt) == RES - 1);
    x_hit       = ENABLE && (int'(bit_cnt) < RES) &&
                  ({1'b0, COUNT} == bit_position(X_FIRST_COUNT, int'(bit_cnt)));
    y_hit       = ENABLE && (int'(bit_cnt) < RES) &&
                  ({1'b0, COUNT} == bit_position(Y_FIRST_COUNT, int'(bit_cnt)));
    shift_nxt   = {shift_q[RES-2:0], ADC_DOUT};
  end

  // frame sequencing, bit capture and registered publication/error pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      x_hold     <= '0;
      X_COORD    <= '0;
      Y_COORD    <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start && PEN_DOWN) begin
            state   <= ST_RX_X;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end
        ST_RX_X, ST_RX_Y: begin
          // pen lift wins over everything: the partial frame is meaningless
          if (!PEN_DOWN) begin
            state     <= ST_IDLE;
            FRAME_ERR <= 1'b1;
          end else if (frame_start) begin
            state     <= ST_RX_X;
            bit_cnt   <= '0;
            shift_q   <= '0;
            FRAME_ERR <= 1'b1;
          end else if (state == ST_RX_X && x_hit) begin
            if (last_bit) begin
              x_hold  <= shift_nxt;
              shift_q <= '0;
              bit_cnt <= '0;
              state   <= ST_RX_Y;
            end else begin
              shift_q <= shift_nxt;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (state == ST_RX_Y && y_hit) begin
            if (last_bit) begin
              X_COORD    <= x_hold;
              Y_COORD    <= shift_nxt;
              DATA_VALID <= 1'b1;
              shift_q    <= '0;
              bit_cnt    <= '0;
              state      <= ST_IDLE;
            end else begin
              shift_q <= shift_nxt;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          shift_q <= '0;
        end
      endcase
    end
  end

endmodule
